// File: rtl/result_deskew.sv
`default_nettype none
// ============================================================================
// Module   : result_deskew
// Purpose  : Realigns the column-skewed bottom-row partial sums of a systolic
//            array into complete result rows. Aligned rows are buffered in a
//            small FIFO with a valid/ready output. Completion of a pass is
//            flagged on done.
// Revision : 1.0 - initial release
// ============================================================================
module result_deskew #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             general_enable,
  input  logic                             start,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] psum_in,
  input  logic [MATRIX_SIZE-1:0]           psum_valid,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] row_data,
  output logic                             row_valid,
  output logic                             row_last,
  input  logic                             row_ready,
  output logic                             done,
  output logic                             overflow,
  output logic                             skew_error
);

  localparam int ROW_W = MATRIX_SIZE * DATA_SIZE;
  localparam int CNT_W = $clog2(MATRIX_SIZE) + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(MATRIX_SIZE - 1);
  localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // --------------------------------------------------------------------------
  // Deskew: column j is delayed by MATRIX_SIZE-1-j stages so every column of
  // a row reaches the aligned boundary together. The last column is direct.
  // --------------------------------------------------------------------------
  logic [ROW_W-1:0]       w_al_data;
  logic [MATRIX_SIZE-1:0] w_al_valid;

  genvar gj;
  generate
    for (gj = 0; gj < MATRIX_SIZE - 1; gj++) begin : g_col_delay
      localparam int STAGES = MATRIX_SIZE - 1 - gj;

      logic [STAGES*DATA_SIZE-1:0]     r_sd;
      logic [STAGES-1:0]               r_sv;
      logic [(STAGES+1)*DATA_SIZE-1:0] w_sd_chain;
      logic [STAGES:0]                 w_sv_chain;

      // The chain holds the new input at the bottom; its top slot is the
      // aligned output, the rest is what the stages capture next.
      assign w_sd_chain = {r_sd, psum_in[gj*DATA_SIZE +: DATA_SIZE]};
      assign w_sv_chain = {r_sv, psum_valid[gj]};

      // Shift the column delay line; held while disabled, flushed on start
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sd <= '0;
          r_sv <= '0;
        end else if (start) begin
          r_sd <= '0;
          r_sv <= '0;
        end else if (general_enable) begin
          r_sd <= w_sd_chain[STAGES*DATA_SIZE-1:0];
          r_sv <= w_sv_chain[STAGES-1:0];
        end
      end

      assign w_al_data[gj*DATA_SIZE +: DATA_SIZE] = w_sd_chain[(STAGES+1)*DATA_SIZE-1 -: DATA_SIZE];
      assign w_al_valid[gj]                       = w_sv_chain[STAGES];
    end : g_col_delay
  endgenerate

  assign w_al_data[ROW_W-1 -: DATA_SIZE] = psum_in[ROW_W-1 -: DATA_SIZE];
  assign w_al_valid[MATRIX_SIZE-1]       = psum_valid[MATRIX_SIZE-1];

  // --------------------------------------------------------------------------
  // Row classification. Inputs are ignored while disabled, and a start cycle
  // only restarts the pass (it never pushes or flags).
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_row_cnt;
  logic             w_row_present;
  logic             w_any_valid;
  logic             w_take;
  logic             w_mixed;
  logic             w_in_collect;
  logic             w_last_row;

  assign w_row_present = general_enable & (&w_al_valid);
  assign w_any_valid   = general_enable & (|w_al_valid);
  assign w_take        = w_row_present & ~start;
  assign w_mixed       = w_any_valid & ~w_row_present & ~start;
  assign w_in_collect  = (r_state == S_COLLECT);
  assign w_last_row    = (r_row_cnt == LAST_ROW);

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  logic [ROW_W-1:0] r_mem_data [FIFO_DEPTH];
  logic             r_mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_empty_after;

  assign w_full  = (r_occ == OCC_FULL);
  assign w_empty = (r_occ == '0);
  assign w_pop   = ~w_empty & row_ready;
  // A full FIFO still accepts a row when the head leaves on the same edge
  assign w_push  = w_take & w_in_collect & (~w_full | w_pop);
  assign w_drop  = w_take & w_in_collect & w_full & ~w_pop;
  // Empty after this edge, counting a pop that empties it right now
  assign w_empty_after = w_empty | ((r_occ == OCC_W'(1)) & w_pop & ~w_push);

  // Store the aligned row and its last-row marker at the write pointer
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_al_data;
      r_mem_last[r_wr_ptr] <= w_last_row;
    end
  end

  // Advance FIFO pointers and occupancy; start deliberately leaves the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_MAX) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_MAX) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign row_valid = ~w_empty;
  assign row_data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign row_last  = ~w_empty & r_mem_last[r_rd_ptr];

  // Count aligned rows of the pass, dropped ones included
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_cnt <= '0;
    end else if (start) begin
      r_row_cnt <= '0;
    end else if (w_take && w_in_collect) begin
      r_row_cnt <= r_row_cnt + CNT_W'(1);
    end
  end

  // Sticky error flags, cleared when a new pass starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      skew_error <= 1'b0;
    end else if (start) begin
      overflow   <= 1'b0;
      skew_error <= 1'b0;
    end else begin
      if (w_drop) begin
        overflow <= 1'b1;
      end
      if (w_mixed || (w_take && !w_in_collect)) begin
        skew_error <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pass sequencing
  // --------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_COLLECT;
      S_COLLECT: if (w_take && w_last_row) w_state_next = S_DRAIN;
      S_DRAIN:   if (w_empty_after) w_state_next = S_DONE;
      S_DONE:    if (start) w_state_next = S_COLLECT;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    done = (r_state == S_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_result_deskew.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_deskew
// Purpose  : Scoreboard bench for result_deskew: a 2x2 instance with a deep
//            FIFO and a 4x4 instance with a 2-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_deskew;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 2x2 instance, FIFO depth 4
  logic        a_en, a_start, a_rdy, a_vld, a_last, a_done, a_ovf, a_skew;
  logic [15:0] a_psum, a_data;
  logic [1:0]  a_pv;
  // 4x4 instance, FIFO depth 2
  logic        b_en, b_start, b_rdy, b_vld, b_last, b_done, b_ovf, b_skew;
  logic [31:0] b_psum, b_data;
  logic [3:0]  b_pv;

  result_deskew #(.MATRIX_SIZE(2), .DATA_SIZE(8), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .reset(reset), .general_enable(a_en), .start(a_start),
    .psum_in(a_psum), .psum_valid(a_pv), .row_data(a_data), .row_valid(a_vld),
    .row_last(a_last), .row_ready(a_rdy), .done(a_done), .overflow(a_ovf),
    .skew_error(a_skew)
  );

  result_deskew #(.MATRIX_SIZE(4), .DATA_SIZE(8), .FIFO_DEPTH(2)) u_dut_b (
    .clk(clk), .reset(reset), .general_enable(b_en), .start(b_start),
    .psum_in(b_psum), .psum_valid(b_pv), .row_data(b_data), .row_valid(b_vld),
    .row_last(b_last), .row_ready(b_rdy), .done(b_done), .overflow(b_ovf),
    .skew_error(b_skew)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] a_sb[$];
  logic [63:0] b_sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Element of row r, column c; key varies the pattern between passes
  function automatic logic [7:0] elem(input int r, input int c, input logic [7:0] key);
    return 8'((r + 1) * 16 + (c + 1)) ^ key;
  endfunction

  // Scoreboard comparison whenever a head row is accepted
  always @(negedge clk) begin
    if (!reset && a_vld && a_rdy)
      check("a_row", {47'd0, a_last, a_data}, (a_sb.size() > 0) ? a_sb.pop_front() : 64'hx);
    if (!reset && b_vld && b_rdy)
      check("b_row", {31'd0, b_last, b_data}, (b_sb.size() > 0) ? b_sb.pop_front() : 64'hx);
  end

  // Skewed step t for the 2x2 array: column c carries row t-c
  task automatic a_drive(input int t, input logic [7:0] key);
    int r;
    a_pv   = '0;
    a_psum = '0;
    for (int c = 0; c < 2; c++) begin
      r = t - c;
      if (r >= 0 && r < 2) begin
        a_pv[c] = 1'b1;
        a_psum[c*8 +: 8] = elem(r, c, key);
      end
    end
    r = t - 1;
    if (r >= 0 && r < 2)
      a_sb.push_back({47'd0, (r == 1), elem(r, 1, key), elem(r, 0, key)});
  endtask

  task automatic a_pass(input int stall, input logic [7:0] key, output int lat);
    int t;
    int held;
    t = 0; held = 0; lat = 0;
    a_rdy = 1'b1; a_en = 1'b1;
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("a_done_clr", a_done, 0);
    while (t < 3) begin
      if (t == 1 && held < stall) begin
        a_en = 1'b0; a_pv = 2'b11; a_psum = 16'hdead; held++;
      end else begin
        a_en = 1'b1; a_drive(t, key); t++;
      end
      tick(); lat++;
    end
    a_en = 1'b1; a_pv = '0; a_psum = '0;
    while (!a_done && lat < 40) begin
      tick(); lat++;
    end
    check("a_done", a_done, 1);
    check("a_skew_clean", a_skew, 0);
    check("a_ovf_clean", a_ovf, 0);
  endtask

  // Skewed step t for the 4x4 array; only the first 'keep' rows are expected
  task automatic b_drive(input int t, input logic [7:0] key, input int keep);
    int r;
    b_pv   = '0;
    b_psum = '0;
    for (int c = 0; c < 4; c++) begin
      r = t - c;
      if (r >= 0 && r < 4) begin
        b_pv[c] = 1'b1;
        b_psum[c*8 +: 8] = elem(r, c, key);
      end
    end
    r = t - 3;
    if (r >= 0 && r < keep)
      b_sb.push_back({31'd0, (r == 3), elem(r, 3, key), elem(r, 2, key),
                      elem(r, 1, key), elem(r, 0, key)});
  endtask

  task automatic b_pass(input int ready_from, input int keep, input logic [7:0] key);
    int n;
    b_en = 1'b1; b_rdy = 1'b0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    check("b_done_clr", b_done, 0);
    check("b_ovf_clr", b_ovf, 0);
    for (int t = 0; t < 7; t++) begin
      b_rdy = (ready_from >= 0 && t >= ready_from);
      b_drive(t, key, keep);
      tick();
    end
    b_pv = '0; b_psum = '0;
    check("b_ovf", b_ovf, (keep < 4));
    if (ready_from < 0) begin
      tick(); tick();
      check("b_hold_vld", b_vld, 1);
      check("b_hold_done", b_done, 0);
    end
    b_rdy = 1'b1;
    n = 0;
    while (!b_done && n < 40) begin
      tick(); n++;
    end
    check("b_done", b_done, 1);
    check("b_skew", b_skew, 0);
  endtask

  initial begin
    int lat0;
    int lat1;
    reset = 1'b1;
    a_en = 1'b1; a_start = 1'b0; a_rdy = 1'b1; a_pv = '0; a_psum = '0;
    b_en = 1'b1; b_start = 1'b0; b_rdy = 1'b0; b_pv = '0; b_psum = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Aligned data while idle is rejected and flagged
    a_pv = 2'b11; a_psum = 16'h5a5a;
    tick(); tick();
    check("idle_skew", a_skew, 1);
    check("idle_vld", a_vld, 0);
    a_pv = '0; a_psum = '0;

    // Mid-cycle reset clears outputs without waiting for a clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_data", a_data, 0);
    check("rst_vld", a_vld, 0);
    check("rst_last", a_last, 0);
    check("rst_done", a_done, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_skew", a_skew, 0);
    tick(); reset = 1'b0; tick();

    // Basic pass, then the same pass with a 3-cycle enable stall
    a_pass(0, 8'h00, lat0);
    check("a_lat", lat0, 4);
    a_pass(3, 8'h3c, lat1);
    check("a_stall_shift", lat1 - lat0, 3);

    // Column 1 valid without its column 0 partner
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("skew_clr", a_skew, 0);
    a_pv = 2'b00; tick();
    a_pv = 2'b10; a_psum = 16'h7700; tick();
    a_pv = '0; a_psum = '0;
    check("skew_set", a_skew, 1);
    check("skew_no_push", a_vld, 0);
    tick();
    check("skew_still_empty", a_vld, 0);

    // Reset mid-pass with a row sitting in the FIFO, then a clean pass
    a_rdy = 1'b0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_pv = 2'b01; a_psum = 16'h0011; tick();
    a_pv = 2'b11; a_psum = 16'h2112; tick();
    a_pv = '0; a_psum = '0;
    check("mid_vld", a_vld, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_vld", a_vld, 0);
    check("mid_rst_done", a_done, 0);
    tick(); reset = 1'b0; tick();
    a_pass(0, 8'h81, lat0);
    check("a_lat_post_rst", lat0, 4);

    // Full FIFO with a pop on the same edge as a push, then overflow
    b_pass(5, 4, 8'h00);
    b_pass(-1, 2, 8'h5f);

    tick(); tick();
    check("a_sb_left", a_sb.size(), 0);
    check("b_sb_left", b_sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
